// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 tables, GF(2^8) helpers, round count and core state encoding.
//   NR          number of AES-128 rounds (fixed at 10)
//   SBOX        forward S-box, SBOX[0] is the entry for byte 8'h00
//   INV_SBOX    inverse S-box
//   RCON        key-schedule round constants, RCON[0] is used for rk1
//   aesStateT   core FSM states
package aes_pkg;

   localparam int NR = 10;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

   typedef enum logic [2:0] {IDLE, KEY_EXPAND, WHITEN, ROUNDS, DONE} aesStateT;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ x : p;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES round, forward or inverse.
//   state      128-bit round input, byte 0 in [127:120], column-major
//   roundKey   key added in this round
//   decrypt    0 = Sub/Shift/Mix/AddKey, 1 = InvShift/InvSub/AddKey/InvMix
//   lastRound  skips (Inv)MixColumns
//   nextState  round output
module aes_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] roundKey,
   input  logic         decrypt,
   input  logic         lastRound,
   output logic [127:0] nextState
);

   logic [0:15][7:0] inBytes;
   logic [0:15][7:0] subBytes;
   logic [0:15][7:0] mixIn;
   logic [0:15][7:0] mixed;
   logic [0:3][7:0]  coef;
   logic [127:0]     preKey;

   assign inBytes = state;
   // MixColumns matrix row 0; later rows are rotations of it
   assign coef = decrypt ? 32'h0e0b0d09 : 32'h02030101;

   always_comb begin
      subBytes = '0;
      mixed = '0;
      // byte i sits at row i%4, column i/4; shifting and substitution commute
      for (int i = 0; i < 16; i++)
         subBytes[4'(i)] = decrypt ? INV_SBOX[inBytes[4'(i % 4 + 4 * ((i / 4 - i % 4 + 4) % 4))]]
                                   : SBOX[inBytes[4'(i % 4 + 4 * ((i / 4 + i % 4) % 4))]];
      // the inverse round adds the key before InvMixColumns
      mixIn = decrypt ? subBytes ^ roundKey : subBytes;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
               mixed[4'(4 * c + r)] = mixed[4'(4 * c + r)] ^ gmul(coef[2'(k - r)], mixIn[4'(4 * c + k)]);
   end

   assign preKey = lastRound ? mixIn : mixed;
   assign nextState = decrypt ? preKey : preKey ^ roundKey;

endmodule

// File: rtl/aes128_cipher_core.sv
// aes128_cipher_core: iterative AES-128 encrypt/decrypt engine with a cached key schedule.
//   clock             rising-edge clock
//   resetModule       synchronous active-high reset
//   inputData         plaintext or ciphertext, captured at acceptance
//   key               cipher key, compared against the cached key at acceptance
//   decryptMode       0 = encrypt, 1 = decrypt, captured at acceptance
//   inputsLoadedFlag  level request
//   outputData        result, updated only on completion
//   dataReadyFlag     high while a result is presented
//   busyFlag          high from acceptance until dataReadyFlag rises
module aes128_cipher_core
   import aes_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic         clock,
   input  logic         resetModule,
   input  logic [127:0] inputData,
   input  logic [127:0] key,
   input  logic         decryptMode,
   input  logic         inputsLoadedFlag,
   output logic [127:0] outputData,
   output logic         dataReadyFlag,
   output logic         busyFlag
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : gBadUnroll
      $error("aes128_cipher_core: UNROLL must be 1, 2, 5 or 10");
   end

   localparam logic [3:0] STEP = 4'(UNROLL);
   localparam logic [3:0] LAST_START = 4'(NR - UNROLL + 1);

   aesStateT     state, nextState;
   logic [127:0] roundKeys [11];
   logic [127:0] dataState, cachedKey, prevKey, expandedKey, chainOut;
   logic [31:0]  keyTemp, w0, w1, w2, w3;
   logic [3:0]   keyCounter, roundCounter;
   logic         keyValid, modeReg, cacheHit;

   assign cacheHit = keyValid && key == cachedKey;

   // one key-schedule step: rk[keyCounter] from rk[keyCounter-1]
   assign prevKey = roundKeys[keyCounter - 4'd1];
   assign keyTemp = sub_word(rot_word(prevKey[31:0])) ^ {RCON[keyCounter - 4'd1], 24'h0};
   assign w0 = prevKey[127:96] ^ keyTemp;
   assign w1 = prevKey[95:64] ^ w0;
   assign w2 = prevKey[63:32] ^ w1;
   assign w3 = prevKey[31:0] ^ w2;
   assign expandedKey = {w0, w1, w2, w3};

   for (genvar j = 0; j < UNROLL; j++) begin : gRound
      logic [127:0] roundIn, roundOut;
      logic [3:0]   roundNum, keyIdx;
      if (j == 0) begin : gFirst
         assign roundIn = dataState;
      end else begin : gNext
         assign roundIn = gRound[j - 1].roundOut;
      end
      assign roundNum = roundCounter + 4'(j);
      // decrypt round r consumes rk[NR-r]
      assign keyIdx = modeReg ? 4'(NR) - roundNum : roundNum;
      aes_round uRound (
         .state    (roundIn),
         .roundKey (roundKeys[keyIdx]),
         .decrypt  (modeReg),
         .lastRound(roundNum == 4'(NR)),
         .nextState(roundOut)
      );
   end

   assign chainOut = gRound[UNROLL - 1].roundOut;

   always_ff @(posedge clock) state <= resetModule ? IDLE : nextState;

   always_comb begin
      nextState = state;
      case (state)
         IDLE:       if (inputsLoadedFlag) nextState = cacheHit ? WHITEN : KEY_EXPAND;
         KEY_EXPAND: if (keyCounter == 4'(NR)) nextState = WHITEN;
         WHITEN:     nextState = ROUNDS;
         ROUNDS:     if (roundCounter == LAST_START) nextState = DONE;
         DONE:       if (!inputsLoadedFlag) nextState = IDLE;
         default:    nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (resetModule) begin
         outputData <= '0;
         dataReadyFlag <= 1'b0;
         busyFlag <= 1'b0;
         keyValid <= 1'b0;
         keyCounter <= 4'd1;
         roundCounter <= 4'd1;
      end else begin
         case (state)
            IDLE: if (inputsLoadedFlag) begin
               dataState <= inputData;
               modeReg <= decryptMode;
               busyFlag <= 1'b1;
               keyCounter <= 4'd1;
               roundCounter <= 4'd1;
               if (!cacheHit) begin
                  roundKeys[0] <= key;
                  cachedKey <= key;
                  keyValid <= 1'b0;
               end
            end
            KEY_EXPAND: begin
               roundKeys[keyCounter] <= expandedKey;
               if (keyCounter == 4'(NR)) keyValid <= 1'b1;
               else keyCounter <= keyCounter + 4'd1;
            end
            WHITEN: dataState <= dataState ^ (modeReg ? roundKeys[NR] : roundKeys[0]);
            ROUNDS: begin
               dataState <= chainOut;
               roundCounter <= roundCounter + STEP;
               if (roundCounter == LAST_START) begin
                  outputData <= chainOut;
                  dataReadyFlag <= 1'b1;
                  busyFlag <= 1'b0;
                  roundCounter <= 4'd1;
               end
            end
            DONE: if (!inputsLoadedFlag) dataReadyFlag <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_cipher_core.sv
// tb_aes128_cipher_core: FIPS-197 vectors on four cores (UNROLL 1/2/5/10) driven in lockstep.
module tb_aes128_cipher_core;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

   typedef struct {
      string        name;
      logic [127:0] k;
      logic [127:0] din;
      logic         mode;
      logic [127:0] expOut;
      bit           hit;
   } vecT;

   logic         clock = 1'b0;
   logic         resetModule, decryptMode, inputsLoadedFlag;
   logic [127:0] inputData, key;
   logic [127:0] outData [4];
   logic         ready [4];
   logic         busy [4];
   int           checks = 0;
   int           errors = 0;
   vecT          vecs [4];

   always #5 clock = ~clock;

   for (genvar g = 0; g < 4; g++) begin : gDut
      aes128_cipher_core #(.UNROLL(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)) uDut (
         .clock           (clock),
         .resetModule     (resetModule),
         .inputData       (inputData),
         .key             (key),
         .decryptMode     (decryptMode),
         .inputsLoadedFlag(inputsLoadedFlag),
         .outputData      (outData[g]),
         .dataReadyFlag   (ready[g]),
         .busyFlag        (busy[g])
      );
   end

   function automatic int unrollOf(input int g);
      return g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10;
   endfunction

   function automatic int expLatency(input int g, input bit hit);
      return (hit ? 1 : 11) + 10 / unrollOf(g);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   task automatic checkIdleOutputs(input string name);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_out_u%0d", name, unrollOf(i)), outData[i], '0);
         check($sformatf("%s_ready_u%0d", name, unrollOf(i)), 128'(ready[i]), 128'd0);
         check($sformatf("%s_busy_u%0d", name, unrollOf(i)), 128'(busy[i]), 128'd0);
      end
   endtask

   task automatic runBlock(input vecT v, input bit hold);
      int lat [4];
      bit busyOk [4];
      bit allDone;
      @(negedge clock);
      key = v.k;
      inputData = v.din;
      decryptMode = v.mode;
      inputsLoadedFlag = 1'b1;
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         lat[i] = 0;
         busyOk[i] = busy[i] === 1'b1;
      end
      key = ~v.k;
      inputData = ~v.din;
      decryptMode = ~v.mode;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clock);
         #1;
         allDone = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (n <= expLatency(i, v.hit) && busy[i] !== (n < expLatency(i, v.hit))) busyOk[i] = 1'b0;
            if (lat[i] == 0 && ready[i] === 1'b1) lat[i] = n;
            if (lat[i] == 0) allDone = 1'b0;
         end
         if (allDone) break;
      end
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_latency_u%0d", v.name, unrollOf(i)), 128'(lat[i]), 128'(expLatency(i, v.hit)));
         check($sformatf("%s_busy_u%0d", v.name, unrollOf(i)), 128'(busyOk[i]), 128'd1);
         check($sformatf("%s_data_u%0d", v.name, unrollOf(i)), outData[i], v.expOut);
      end
      if (!hold) begin
         @(negedge clock);
         inputsLoadedFlag = 1'b0;
         @(posedge clock);
         #1;
         for (int i = 0; i < 4; i++)
            check($sformatf("%s_drop_u%0d", v.name, unrollOf(i)), 128'(ready[i]), 128'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit stable [4];
      vecT v;
      vecs[0] = '{"enc_k1", K1, P1, 1'b0, C1, 1'b0};
      vecs[1] = '{"dec_k1_hit", K1, C1, 1'b1, P1, 1'b1};
      vecs[2] = '{"enc_k2", K2, P2, 1'b0, C2, 1'b0};
      vecs[3] = '{"dec_k2_hit", K2, C2, 1'b1, P2, 1'b1};

      resetModule = 1'b1;
      inputsLoadedFlag = 1'b0;
      decryptMode = 1'b0;
      inputData = '0;
      key = '0;
      repeat (2) @(posedge clock);
      #1;
      checkIdleOutputs("reset");
      @(negedge clock);
      resetModule = 1'b0;

      for (int t = 0; t < 4; t++) runBlock(vecs[t], 1'b0);

      v = '{"held", K2, P2, 1'b0, C2, 1'b1};
      runBlock(v, 1'b1);
      @(negedge clock);
      key = K2;
      inputData = P2;
      for (int i = 0; i < 4; i++) stable[i] = 1'b1;
      repeat (100) begin
         @(posedge clock);
         #1;
         for (int i = 0; i < 4; i++)
            if (busy[i] !== 1'b0 || ready[i] !== 1'b1 || outData[i] !== C2) stable[i] = 1'b0;
      end
      for (int i = 0; i < 4; i++)
         check($sformatf("held_stable_u%0d", unrollOf(i)), 128'(stable[i]), 128'd1);
      @(negedge clock);
      inputsLoadedFlag = 1'b0;
      @(posedge clock);

      @(negedge clock);
      key = K1;
      inputData = P1;
      decryptMode = 1'b0;
      inputsLoadedFlag = 1'b1;
      repeat (6) @(posedge clock);
      @(negedge clock);
      resetModule = 1'b1;
      inputsLoadedFlag = 1'b0;
      @(posedge clock);
      #1;
      checkIdleOutputs("midreset");
      @(negedge clock);
      resetModule = 1'b0;
      v = '{"after_reset", K1, P1, 1'b0, C1, 1'b0};
      runBlock(v, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes128_cipher_core.md
Name: aes128_cipher_core

Overview:
- Iterative AES-128 engine that performs either encryption or decryption, selected per block, on one 128-bit block per transaction.
- It is the next-generation replacement for the decryption-only core and keeps the same flag-style handshake.
- Configurable unroll: UNROLL rounds are evaluated per clock.
- Holds an 11-entry round-key cache, so key expansion is skipped when a block arrives with the same key as the previous block.

Parameters:
- UNROLL, 1: AES rounds per clock. Legal values are 1, 2, 5, 10. Any other value fails elaboration.
- NR, 10: number of AES-128 rounds. Fixed; exposed as a constant only, not overridable.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- resetModule  input  1  synchronous, active-high reset.
- inputData  input  128  plaintext (encrypt) or ciphertext (decrypt).
- key  input  128  cipher key.
- decryptMode  input  1  0 = encrypt, 1 = decrypt. Sampled at acceptance.
- inputsLoadedFlag  input  1  level request; inputData, key and decryptMode must be valid while it is high.
- outputData  output  128  result; held stable while dataReadyFlag = 1.
- dataReadyFlag  output  1  high while a result is presented.
- busyFlag  output  1  high from acceptance until dataReadyFlag rises.

Behaviour:
- Reset (any state, including mid-operation): state = IDLE; outputData = 0; dataReadyFlag = 0; busyFlag = 0; keyValid = 0. Round-key registers need not be cleared.
- States: IDLE, KEY_EXPAND, WHITEN, ROUNDS, DONE.
- IDLE to next state, when inputsLoadedFlag = 1:
  - Capture inputData into the state register, capture decryptMode, set busyFlag = 1.
  - Cache hit (keyValid = 1 and key == cachedKey): go to WHITEN.
  - Otherwise: load rk0 = key, store cachedKey, clear keyValid, go to KEY_EXPAND.
- KEY_EXPAND: 10 cycles, computing rk1 to rk10 (one per edge, using the Rcon sequence). On the 10th edge set keyValid = 1 and go to WHITEN.
- WHITEN: 1 cycle. state ^= rk0 for encrypt, state ^= rk10 for decrypt. Round counter starts at 1.
- ROUNDS: NR/UNROLL cycles; each cycle applies UNROLL rounds.
  - Encrypt round r: SubBytes, ShiftRows, MixColumns (omitted when r = 10), AddRoundKey rk[r].
  - Decrypt round r: InvShiftRows, InvSubBytes, AddRoundKey rk[10-r], InvMixColumns (omitted when r = 10).
  - The final ROUNDS edge writes outputData, sets dataReadyFlag = 1, clears busyFlag, and goes to DONE.
- DONE: outputs hold. When inputsLoadedFlag = 0, clear dataReadyFlag and go to IDLE. A held-high request therefore never retriggers. outputData keeps its last value until the next completion.
- Latency, in edges after the acceptance edge until dataReadyFlag = 1:
  - Cache miss: 11 + NR/UNROLL (UNROLL=1: 21; UNROLL=2: 16; UNROLL=5: 13; UNROLL=10: 12).
  - Cache hit: 1 + NR/UNROLL (11 / 6 / 3 / 2).
- Input changes after acceptance are ignored. decryptMode may differ between consecutive blocks that use a cached key, because the round keys are mode-independent.
- Byte order follows FIPS-197: bit [127:120] is byte 0, and bytes map column-major.
- outputData changes only on the completion edge or on reset.

Decomposition:
- Package aes_pkg:
  - SBOX[256], INV_SBOX[256], RCON[10].
  - Functions xtime, gmul, sub_word, rot_word.
  - Constant NR = 10.
  - State enum {IDLE, KEY_EXPAND, WHITEN, ROUNDS, DONE}.
- Sub-module aes_round: purely combinational single round.
  - Inputs: state[127:0], roundKey[127:0], decrypt, lastRound. Output: next state.
  - The core instantiates UNROLL copies in a chain.
- The key expander stays inline in the core, as one key-schedule step per cycle.

Test Plan:
- Encrypt, UNROLL=1: key 000102030405060708090a0b0c0d0e0f, input 00112233445566778899aabbccddeeff, mode 0 → outputData 69c4e0d86a7b0430d8cdb78070b4c55a; dataReadyFlag rises exactly 21 edges after acceptance.
- Decrypt with cache hit: same key, drop then re-raise the request with input 69c4e0d86a7b0430d8cdb78070b4c55a, mode 1 → 00112233445566778899aabbccddeeff after 11 edges; busyFlag is high for edges 0 to 10.
- New key: key 2b7e151628aed2a6abf7158809cf4f3c, input 3243f6a8885a308d313198a2e0370734, mode 0 → 3925841d02dc09fbdc118597196a0b32 after 21 edges (cache miss). Then decrypt the result back to the original input.
- Held request: keep inputsLoadedFlag high for 100 cycles after DONE → no second transaction, busyFlag stays 0, outputData stable.
- Mid-operation reset: assert resetModule for 1 cycle at edge 5 of KEY_EXPAND → all outputs 0 next edge. A following request with the same key takes the miss latency (21), because keyValid was cleared.
- Unroll sweep: repeat the first three scenarios with UNROLL = 2, 5, 10 → identical data; latencies 16/6, 13/3, 12/2 (miss/hit).
